rom_word_serializer: RTL

//  Downstream consumer of the 16x8 lookup ROM. Generates the ROM address, captures each word and shifts it
//  out MSB-first as a bit stream with a valid/ready handshake. Sits between the ROM and any bit-serial sink
//  (line driver, LED, TX pin). One start pulse streams the whole ROM once; done pulses at the end.

---
 rtl/rom_word_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rom_word_serializer.sv
// Streams every word of a combinational lookup ROM out MSB-first over a valid/ready bit interface.
// Optional feature: define ROM_SER_PARITY_EN to append one even-parity bit after each word.
module rom_word_serializer #(
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input  logic              clock,
    input  logic              clearb,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    // Handshake: a bit transfers on a rising clock edge where ser_valid and ser_ready are both 1;
    // while ser_valid is 1 and ser_ready is 0, ser_out and ser_valid hold their values.

    localparam int CNT_W = $clog2(WORD_W + 1);
`ifdef ROM_SER_PARITY_EN
    localparam int LAST_BIT = WORD_W;
`else
    localparam int LAST_BIT = WORD_W - 1;
`endif
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LAST_BIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign accept = (state_q == SHIFT) && ser_ready;

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state_q <= IDLE;
            addr_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                shreg_d = rom_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (accept) begin
                    shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // The address saturates at the last word so a run never wraps.
                        if (addr_q == LAST_ADDR) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ROM_SER_PARITY_EN
    // Parity comes from the captured word, not the partially shifted register.
    logic parity_q;

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            parity_q <= 1'b0;
        end else if (state_q == FETCH) begin
            parity_q <= ^rom_data;
        end
    end

    assign ser_out = (cnt_q == LAST_CNT) ? parity_q : shreg_q[WORD_W-1];
`else
    assign ser_out = shreg_q[WORD_W-1];
`endif

    assign rom_addr  = addr_q;
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == FETCH) || (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
